thread_sched: RTL and testbench
===============================

Name: thread_sched

Overview:
- Fetch-side thread scheduler, directly downstream of the eight per-thread CSR instances.
- Consumes each thread's valid/running status and current PC.
- Picks one runnable thread per issue slot by round-robin and presents its ID and PC to the fetch stage over a valid/ready handshake.
- Tracks one in-flight fetch per thread, so a thread is not re-issued until the pipeline reports its fetch done or flushed.

Parameters:
- NUM_TRD, 8, number of hardware threads; must equal 2**TRD_W.
- TRD_W, 3, thread ID width; matches the global obj_trd/act_trd width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- trd_valid  input  NUM_TRD  valid outputs of the thread CSRs; bit i = thread i
- trd_running  input  NUM_TRD  running outputs of the thread CSRs
- trd_pc  input  NUM_TRD*32  cur_pc of each thread CSR; thread i occupies bits [32i+31:32i]
- fetch_rdy  input  1  fetch stage accepts the offered thread
- done  input  1  pulse: the in-flight fetch of done_trd has resolved (its PC was written)
- done_trd  input  TRD_W  thread ID qualified by done
- flush  input  1  pulse: squash flush_trd
- flush_trd  input  TRD_W  thread ID qualified by flush
- fetch_vld  output  1  offer valid
- fetch_trd  output  TRD_W  offered thread ID
- fetch_pc  output  32  offered PC, captured from trd_pc at selection
- inflight  output  NUM_TRD  per-thread in-flight flags
- idle  output  1  no thread runnable and no offer pending

Behaviour:
- Reset: fetch_vld=0, fetch_trd=0, fetch_pc=0, inflight=0, rr_ptr=0, idle=1.
- Runnable: runnable[i] = trd_valid[i] & trd_running[i] & ~inflight[i].
- Selection mask: the runnable mask with the bit of the thread accepted in the current cycle also cleared.
- Selection: first set bit of the selection mask, searching from rr_ptr upward and wrapping NUM_TRD-1 -> 0.
- Output register: all offer outputs (fetch_vld, fetch_trd, fetch_pc) are registered; a selection appears one cycle after it is made.
  - The register loads when it is empty or its offer is accepted this cycle.
  - On load: fetch_vld = any bit of the selection mask set; fetch_trd and fetch_pc come from the selected thread.
- Hold rule: while fetch_vld=1 and fetch_rdy=0, fetch_trd and fetch_pc stay stable.
  - The offer is never retracted because trd_running or trd_valid drops; only flush retracts it.
- Accept (fetch_vld & fetch_rdy):
  - inflight[fetch_trd] sets next cycle.
  - rr_ptr becomes fetch_trd+1, mod NUM_TRD.
- Done: inflight[done_trd] clears next cycle. A done for a thread that is not in flight is ignored.
- Flush:
  - inflight[flush_trd] clears next cycle.
  - If fetch_vld=1 and fetch_trd==flush_trd, fetch_vld=0 next cycle and no accept is recorded, even if fetch_rdy=1 in the same cycle.
  - The register may reload that cycle with a different thread.
- Simultaneous set and clear of the same inflight bit in one cycle: the set (from an accept) wins.
- Back-to-back issue: a different runnable thread can be accepted every cycle. A single runnable thread issues at most once per done/flush round trip.
- idle = ~fetch_vld & ~|runnable. It is combinational from the registered state and the current inputs.
- No state machine beyond the output register, the inflight vector and rr_ptr. An asynchronous reset at any time returns everything to the reset values.

Optional Feature:
- Macro: THREAD_SCHED_STAT_EN.
- When defined, adds two 32-bit output ports:
  - stat_issue: counts accepts.
  - stat_bubble: counts cycles with fetch_vld=0 while at least one of trd_valid is set.
  - Both counters reset to 0, saturate at 0xFFFFFFFF and never wrap.
- When not defined, these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package (existing header.svh scope): NUM_TRD, TRD_W, a trd_id_t typedef of TRD_W bits, and START_PC.
- One natural sub-module: rr_arbiter.
  - Inputs: NUM_TRD-bit request mask and TRD_W-bit start pointer.
  - Outputs: grant valid, one-hot grant and encoded grant index.
  - Purely combinational.

Test Plan:
- Reset release with trd_valid=trd_running=0x01, trd_pc[0]=0x1000, fetch_rdy=1 -> fetch_vld=1, fetch_trd=0, fetch_pc=0x1000 one cycle later; the next cycle fetch_vld=0 and inflight=0x01; done with done_trd=0 -> reissues thread 0 two cycles later.
- All eight threads running, fetch_rdy=1, done never asserted -> fetch_trd sequence 0,1,…,7 on consecutive cycles, then fetch_vld=0, inflight=0xFF, idle=1.
- Threads 2 and 5 running, fetch_rdy held 0 for 4 cycles -> fetch_trd=2 and fetch_pc stay stable for all 4 cycles; releasing fetch_rdy -> thread 5 is offered next.
- Offer of thread 3 pending, flush with flush_trd=3 and fetch_rdy=1 in the same cycle -> no accept, inflight[3]=0, fetch_vld drops or reloads with another runnable thread.
- Accept of thread 4 in the same cycle as done with done_trd=4 -> inflight[4]=1 afterwards (set wins).
- THREAD_SCHED_STAT_EN defined, 10 accepts and 3 bubble cycles with trd_valid≠0 -> stat_issue=10, stat_bubble=3.

Source files
------------

// File: rtl/thread_sched_pkg.sv
// Shared thread constants and types for the fetch-side scheduler.
// Holds thread count, ID width, ID type and the boot PC.
package thread_sched_pkg;

  localparam int NUM_TRD = 8;
  localparam int TRD_W   = 3;

  localparam logic [31:0] START_PC = 32'h0000_0000;

  typedef logic [TRD_W-1:0] trd_id_t;

  function automatic logic [NUM_TRD-1:0] trd_oh(
    input trd_id_t id
  );
    return NUM_TRD'(1) << id;
  endfunction

endpackage

// File: rtl/thread_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr_i,
// wrapping at N-1 -> 0. N must equal 2**W.
module thread_sched_rr_arbiter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         gnt_vld_o,
  output logic [N-1:0] gnt_oh_o,
  output logic [W-1:0] gnt_idx_o
);

  logic [W-1:0] idx;

  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    idx       = '0;
    // W-bit addition wraps the search back to thread 0
    for (int i = 0; i < N; i++) begin
      idx = ptr_i + W'(i);
      if (!gnt_vld_o && req_i[idx]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = idx;
      end
    end
    gnt_oh_o = gnt_vld_o ? (N'(1) << gnt_idx_o) : '0;
  end

endmodule

// File: rtl/thread_sched.sv
// Fetch-side round-robin thread scheduler with per-thread in-flight
// tracking. THREAD_SCHED_STAT_EN adds issue/bubble counters.
module thread_sched
  import thread_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_TRD-1:0]    trd_valid,
  input  logic [NUM_TRD-1:0]    trd_running,
  input  logic [NUM_TRD*32-1:0] trd_pc,
  input  logic                  fetch_rdy,
  input  logic                  done,
  input  trd_id_t               done_trd,
  input  logic                  flush,
  input  trd_id_t               flush_trd,
  output logic                  fetch_vld,
  output trd_id_t               fetch_trd,
  output logic [31:0]           fetch_pc,
  output logic [NUM_TRD-1:0]    inflight,
  output logic                  idle
`ifdef THREAD_SCHED_STAT_EN
  ,
  output logic [31:0]           stat_issue,
  output logic [31:0]           stat_bubble
`endif
);

  logic               vld_q, vld_d;
  trd_id_t            trd_q, trd_d;
  logic [31:0]        pc_q, pc_d;
  logic [NUM_TRD-1:0] infl_q, infl_d;
  trd_id_t            rr_q, rr_d;

  logic               kill;
  logic               accept;
  logic               load;
  logic [NUM_TRD-1:0] runnable;
  logic [NUM_TRD-1:0] sel_mask;
  logic [NUM_TRD-1:0] set_v;
  logic [NUM_TRD-1:0] clr_v;
  logic               gnt_vld;
  logic [NUM_TRD-1:0] gnt_oh;
  trd_id_t            gnt_idx;
  logic [31:0]        sel_pc;

  always_comb begin
    kill     = vld_q & flush & (flush_trd == trd_q);
    accept   = vld_q & fetch_rdy & ~kill;
    load     = ~vld_q | accept | kill;
    runnable = trd_valid & trd_running & ~infl_q;
    sel_mask = runnable;
    // the thread leaving the register must not be picked again
    if (accept) sel_mask &= ~trd_oh(trd_q);
    if (kill)   sel_mask &= ~trd_oh(flush_trd);
  end

  thread_sched_rr_arbiter #(
    .N (NUM_TRD),
    .W (TRD_W)
  ) u_arb (
    .req_i     (sel_mask),
    .ptr_i     (rr_q),
    .gnt_vld_o (gnt_vld),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    sel_pc = '0;
    for (int i = 0; i < NUM_TRD; i++) begin
      sel_pc |= trd_pc[32*i +: 32] & {32{gnt_oh[i]}};
    end
  end

  always_comb begin
    vld_d = vld_q;
    trd_d = trd_q;
    pc_d  = pc_q;
    if (load) begin
      vld_d = gnt_vld;
      trd_d = gnt_idx;
      pc_d  = sel_pc;
    end
    rr_d  = accept ? trd_q + trd_id_t'(1) : rr_q;
    set_v = accept ? trd_oh(trd_q) : '0;
    clr_v = '0;
    if (done)  clr_v |= trd_oh(done_trd);
    if (flush) clr_v |= trd_oh(flush_trd);
    // set after clear so a same-cycle accept wins
    infl_d = (infl_q & ~clr_v) | set_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      trd_q  <= '0;
      pc_q   <= '0;
      infl_q <= '0;
      rr_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      trd_q  <= trd_d;
      pc_q   <= pc_d;
      infl_q <= infl_d;
      rr_q   <= rr_d;
    end
  end

  assign fetch_vld = vld_q;
  assign fetch_trd = trd_q;
  assign fetch_pc  = pc_q;
  assign inflight  = infl_q;
  assign idle      = ~vld_q & ~|runnable;

`ifdef THREAD_SCHED_STAT_EN
  logic [31:0] issue_q, issue_d;
  logic [31:0] bubble_q, bubble_d;

  always_comb begin
    issue_d  = issue_q;
    bubble_d = bubble_q;
    if (accept && issue_q != '1) begin
      issue_d = issue_q + 32'd1;
    end
    if (!vld_q && |trd_valid && bubble_q != '1) begin
      bubble_d = bubble_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_q  <= '0;
      bubble_q <= '0;
    end else begin
      issue_q  <= issue_d;
      bubble_q <= bubble_d;
    end
  end

  assign stat_issue  = issue_q;
  assign stat_bubble = bubble_q;
`endif

endmodule

// File: tb/tb_thread_sched.sv
// Directed bench for thread_sched; stat counters checked when
// THREAD_SCHED_STAT_EN is defined.
module tb_thread_sched;
  import thread_sched_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_TRD-1:0]    trd_valid;
  logic [NUM_TRD-1:0]    trd_running;
  logic [NUM_TRD*32-1:0] trd_pc;
  logic                  fetch_rdy;
  logic                  done;
  trd_id_t               done_trd;
  logic                  flush;
  trd_id_t               flush_trd;
  logic                  fetch_vld;
  trd_id_t               fetch_trd;
  logic [31:0]           fetch_pc;
  logic [NUM_TRD-1:0]    inflight;
  logic                  idle;
`ifdef THREAD_SCHED_STAT_EN
  logic [31:0]           stat_issue;
  logic [31:0]           stat_bubble;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  thread_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trd_valid   (trd_valid),
    .trd_running (trd_running),
    .trd_pc      (trd_pc),
    .fetch_rdy   (fetch_rdy),
    .done        (done),
    .done_trd    (done_trd),
    .flush       (flush),
    .flush_trd   (flush_trd),
    .fetch_vld   (fetch_vld),
    .fetch_trd   (fetch_trd),
    .fetch_pc    (fetch_pc),
    .inflight    (inflight),
    .idle        (idle)
`ifdef THREAD_SCHED_STAT_EN
    ,
    .stat_issue  (stat_issue),
    .stat_bubble (stat_bubble)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timed out");
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(
    input logic [7:0] v,
    input logic [7:0] r,
    input logic       rdy
  );
    rst_n       = 1'b0;
    done        = 1'b0;
    flush       = 1'b0;
    done_trd    = '0;
    flush_trd   = '0;
    trd_valid   = v;
    trd_running = r;
    fetch_rdy   = rdy;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    trd_valid   = '0;
    trd_running = '0;
    fetch_rdy   = 1'b0;
    done        = 1'b0;
    done_trd    = '0;
    flush       = 1'b0;
    flush_trd   = '0;
    for (int i = 0; i < NUM_TRD; i++) begin
      trd_pc[32*i +: 32] = 32'h1000 + 32'(i) * 32'h100;
    end
    #2;
    chk("rst_vld", 32'(fetch_vld), 0);
    chk("rst_trd", 32'(fetch_trd), 0);
    chk("rst_pc", fetch_pc, 0);
    chk("rst_infl", 32'(inflight), 0);
    chk("rst_idle", 32'(idle), 1);

    // single thread round trip
    do_reset(8'h01, 8'h01, 1'b1);
    chk("t1_idle0", 32'(idle), 0);
    step();
    chk("t1_vld", 32'(fetch_vld), 1);
    chk("t1_trd", 32'(fetch_trd), 0);
    chk("t1_pc", fetch_pc, 32'h1000);
    step();
    chk("t1_vld_off", 32'(fetch_vld), 0);
    chk("t1_infl", 32'(inflight), 32'h01);
    chk("t1_idle1", 32'(idle), 1);
    done     = 1'b1;
    done_trd = 3'd0;
    step();
    done = 1'b0;
    chk("t1_infl_clr", 32'(inflight), 0);
    chk("t1_vld_gap", 32'(fetch_vld), 0);
    step();
    chk("t1_reissue_vld", 32'(fetch_vld), 1);
    chk("t1_reissue_trd", 32'(fetch_trd), 0);

    // all eight back to back
    do_reset(8'hFF, 8'hFF, 1'b1);
    step();
    chk("t2_trd0", 32'(fetch_trd), 0);
    for (int k = 1; k < 8; k++) begin
      step();
      chk("t2_vld", 32'(fetch_vld), 1);
      chk("t2_trd", 32'(fetch_trd), 32'(k));
    end
    step();
    chk("t2_vld_end", 32'(fetch_vld), 0);
    chk("t2_infl", 32'(inflight), 32'hFF);
    chk("t2_idle", 32'(idle), 1);

    // hold under backpressure, running drop does not retract
    do_reset(8'h24, 8'h24, 1'b0);
    step();
    chk("t3_trd", 32'(fetch_trd), 2);
    chk("t3_pc", fetch_pc, 32'h1200);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) trd_running = 8'h20;
      step();
      chk("t3_hold_vld", 32'(fetch_vld), 1);
      chk("t3_hold_trd", 32'(fetch_trd), 2);
      chk("t3_hold_pc", fetch_pc, 32'h1200);
    end
    fetch_rdy = 1'b1;
    step();
    chk("t3_next_vld", 32'(fetch_vld), 1);
    chk("t3_next_trd", 32'(fetch_trd), 5);
    chk("t3_next_pc", fetch_pc, 32'h1500);
    chk("t3_infl", 32'(inflight), 32'h04);

    // flush of the pending offer with ready high
    do_reset(8'h48, 8'h48, 1'b0);
    step();
    chk("t4_trd", 32'(fetch_trd), 3);
    flush     = 1'b1;
    flush_trd = 3'd3;
    fetch_rdy = 1'b1;
    step();
    flush     = 1'b0;
    fetch_rdy = 1'b0;
    chk("t4_reload_vld", 32'(fetch_vld), 1);
    chk("t4_reload_trd", 32'(fetch_trd), 6);
    chk("t4_infl", 32'(inflight), 0);

    // accept and done on the same thread: set wins
    do_reset(8'h10, 8'h10, 1'b0);
    step();
    chk("t5_trd", 32'(fetch_trd), 4);
    done      = 1'b1;
    done_trd  = 3'd4;
    fetch_rdy = 1'b1;
    step();
    done = 1'b0;
    chk("t5_infl_set", 32'(inflight), 32'h10);
    chk("t5_vld", 32'(fetch_vld), 0);
    flush     = 1'b1;
    flush_trd = 3'd4;
    step();
    flush = 1'b0;
    chk("t5_flush_infl", 32'(inflight), 0);
    chk("t5_flush_vld", 32'(fetch_vld), 0);
    step();
    chk("t5_reissue_vld", 32'(fetch_vld), 1);
    chk("t5_reissue_trd", 32'(fetch_trd), 4);

`ifdef THREAD_SCHED_STAT_EN
    do_reset(8'hFF, 8'hFF, 1'b1);
    chk("st_issue0", stat_issue, 0);
    chk("st_bubble0", stat_bubble, 0);
    for (int k = 0; k < 7; k++) step();
    done      = 1'b1;
    done_trd  = 3'd0;
    flush     = 1'b1;
    flush_trd = 3'd1;
    step();
    done  = 1'b0;
    flush = 1'b0;
    chk("st_trd7", 32'(fetch_trd), 7);
    step();
    chk("st_trd0", 32'(fetch_trd), 0);
    step();
    chk("st_trd1", 32'(fetch_trd), 1);
    step();
    chk("st_vld_off", 32'(fetch_vld), 0);
    step();
    step();
    trd_valid = '0;
    chk("st_issue", stat_issue, 10);
    chk("st_bubble", stat_bubble, 3);
    step();
    chk("st_bubble_hold", stat_bubble, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
